// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encodings, the NOP word and small helpers.
`ifndef FETCH_UNIT_PKG_SV
`define FETCH_UNIT_PKG_SV

package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] WARM = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

  // Instruction fetches are word aligned; stray low bits from a target are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

`endif

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: captures the fetched word and its PC + 4, with a squash
// control that clears the valid flag while still capturing the data fields.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic            load,
  input  logic            squash,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_plus4_out,
  output logic            valid_out
);

  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_plus4_q;
  logic            valid_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_q    <= NOP;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (load) begin
      instr_q    <= instr_in;
      pc_plus4_q <= pc_plus4_in;
      valid_q    <= ~squash;
    end
  end

  assign instr_out    = instr_q;
  assign pc_plus4_out = pc_plus4_q;
  assign valid_out    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register and BOOT/WARM/RUN sequencer driving the instruction
// memory read address, feeding the IF/ID register and counting accepted instructions.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0010_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] start_addr,
  input  logic [31:0] mem_instruction,
  output logic [31:0] read_address,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out,
  output logic        valid_out,
  output logic [31:0] fetch_count
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4;
  logic        ifid_load;
  logic        ifid_squash;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    count_d     = count_q;
    ifid_load   = 1'b0;
    ifid_squash = 1'b0;
    case (state_q)
      BOOT: begin
        pc_d    = start_addr;
        state_d = WARM;
      end
      WARM: begin
        // Pipeline primes for one cycle; the captured word is never marked valid.
        ifid_load   = 1'b1;
        ifid_squash = 1'b1;
        state_d     = RUN;
      end
      RUN: begin
        if (redirect) begin
          pc_d        = word_align(redirect_target);
          ifid_load   = 1'b1;
          ifid_squash = 1'b1;
        end else if (!stall) begin
          pc_d      = pc_plus4;
          ifid_load = 1'b1;
          count_d   = count_q + 32'd1;
        end
      end
      default: begin
        state_d = BOOT;
        pc_d    = RESET_PC;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign read_address = pc_q;
  assign fetch_count  = count_q;

  if_id_reg u_if_id_reg (
    .clock        (clock),
    .reset_n      (reset_n),
    .load         (ifid_load),
    .squash       (ifid_squash),
    .instr_in     (mem_instruction),
    .pc_plus4_in  (pc_plus4),
    .instr_out    (instr_out),
    .pc_plus4_out (pc_plus4_out),
    .valid_out    (valid_out)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a reference model pushes expected IF/ID contents to a
// scoreboard per driven cycle, popped and checked after each rising edge.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0010_0000;
  localparam logic [31:0] START    = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] count;
    logic        valid;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] start_addr;
  logic [31:0] mem_instruction;
  logic [31:0] read_address;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] instr_out;
  logic [31:0] pc_plus4_out;
  logic        valid_out;
  logic [31:0] fetch_count;

  int total = 0;
  int bad = 0;
  exp_t sb[$];

  int          m_state;
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start_addr      (start_addr),
    .mem_instruction (mem_instruction),
    .read_address    (read_address),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .instr_out       (instr_out),
    .pc_plus4_out    (pc_plus4_out),
    .valid_out       (valid_out),
    .fetch_count     (fetch_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h2008_0005 + (addr - START);
  endfunction

  assign mem_instruction = mem_word(read_address);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = RESET_PC;
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_count = 32'h0;
    m_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".read_address"}, read_address, RESET_PC);
    check({tag, ".instr_out"}, instr_out, 32'h0);
    check({tag, ".pc_plus4_out"}, pc_plus4_out, 32'h0);
    check({tag, ".valid_out"}, {31'h0, valid_out}, 32'h0);
    check({tag, ".fetch_count"}, fetch_count, 32'h0);
  endtask

  // One clock cycle with the given inputs; the model predicts, the DUT is checked after.
  task automatic step(input string tag, input logic st, input logic rd, input logic [31:0] tgt);
    exp_t        e;
    logic [31:0] w;
    @(negedge clock);
    stall = st;
    redirect = rd;
    redirect_target = tgt;
    #1;
    check({tag, ".pre_read_address"}, read_address, m_pc);
    w = mem_word(m_pc);
    case (m_state)
      0: begin
        m_pc = start_addr;
        m_state = 1;
      end
      1: begin
        m_instr = w;
        m_pc4 = m_pc + 32'd4;
        m_valid = 1'b0;
        m_state = 2;
      end
      default: begin
        if (rd) begin
          m_instr = w;
          m_pc4 = m_pc + 32'd4;
          m_valid = 1'b0;
          m_pc = {tgt[31:2], 2'b00};
        end else if (!st) begin
          m_instr = w;
          m_pc4 = m_pc + 32'd4;
          m_valid = 1'b1;
          m_count = m_count + 32'd1;
          m_pc = m_pc + 32'd4;
        end
      end
    endcase
    e = '{pc: m_pc, instr: m_instr, pc4: m_pc4, count: m_count, valid: m_valid};
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check({tag, ".read_address"}, read_address, e.pc);
    check({tag, ".instr_out"}, instr_out, e.instr);
    check({tag, ".pc_plus4_out"}, pc_plus4_out, e.pc4);
    check({tag, ".valid_out"}, {31'h0, valid_out}, {31'h0, e.valid});
    check({tag, ".fetch_count"}, fetch_count, e.count);
  endtask

  initial begin
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'h0;
    start_addr = START;
    model_reset();
    #1 reset_n = 1'b0;
    #2 check_reset("por");
    repeat (2) @(posedge clock);
    #1 check_reset("por_hold");
    @(posedge clock);
    #2 reset_n = 1'b1;

    // BOOT and WARM must ignore stall and redirect.
    step("boot", 1'b1, 1'b1, 32'h0000_0BAD);
    step("warm", 1'b1, 1'b1, 32'h0000_0BAD);
    step("run0", 1'b0, 1'b0, 32'h0);
    step("run1", 1'b0, 1'b0, 32'h0);
    step("stall0", 1'b1, 1'b0, 32'h0);
    step("stall1", 1'b1, 1'b0, 32'h0);
    step("stall2", 1'b1, 1'b0, 32'h0);
    step("run2", 1'b0, 1'b0, 32'h0);
    step("run3", 1'b0, 1'b0, 32'h0);
    step("redir_stall", 1'b1, 1'b1, 32'h0040_0103);
    step("after_redir", 1'b0, 1'b0, 32'h0);
    step("redir_top", 1'b0, 1'b1, 32'hFFFF_FFFF);
    step("wrap", 1'b0, 1'b0, 32'h0);
    step("post_wrap", 1'b0, 1'b0, 32'h0);

    // Reset between edges must clear outputs without waiting for a clock.
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_reset("midrun");
    @(posedge clock);
    #1 check_reset("midrun_hold");
    @(posedge clock);
    #2 reset_n = 1'b1;
    step("reboot", 1'b0, 1'b0, 32'h0);
    step("rewarm", 1'b0, 1'b0, 32'h0);
    step("rerun0", 1'b0, 1'b0, 32'h0);
    step("rerun1", 1'b0, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
